otter_intr_csr: RTL and testbench

Machine-mode interrupt and CSR unit for the OTTER RISC-V MCU. It latches an external interrupt request and holds mtvec, mepc and mstatus (MIE/MPIE). It generates the one-cycle `intr_taken` strobe that the control-unit decoder turns into pcSource 4 (jump to mtvec). It supplies mepc for the decoder's MRET path (pcSource 5) and serves CSRRW reads and writes from the datapath.

---
 rtl/otter_intr_csr.sv | 158 +++++++++++++++
 tb/tb_otter_intr_csr.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/otter_intr_csr.sv
// Machine-mode interrupt latch, mtvec/mepc/mstatus CSRs and interrupt-entry FSM for the OTTER MCU.
// Optional macro OTTER_INTR_SYNC_EN adds a 2-flop synchronizer on intr_in for asynchronous sources.
module otter_intr_csr #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        intr_in,
  input  logic        instr_done,
  input  logic [31:0] pc_next,
  input  logic        mret_exec,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wd,
  output logic [31:0] csr_rd,
  output logic        intr_taken,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic        mie
);

  typedef enum logic [0:0] {RUN = 1'b0, TAKEN = 1'b1} state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;

  function automatic logic [31:0] word_align(input logic [31:0] value);
    return {value[31:2], 2'b00};
  endfunction

  state_t      state_r, state_nxt;
  logic        req_s, edge_s, done_s, take_s, wr_s;
  logic        prev_r, pending_r;
  logic        mie_r, mpie_r, mie_nxt, mpie_nxt;
  logic [31:0] mtvec_r, mepc_r, mtvec_nxt, mepc_nxt;
  logic [31:0] mstatus_s;

`ifdef OTTER_INTR_SYNC_EN
  logic sync1_r, sync2_r;

  // two-flop synchronizer for an asynchronous request line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= intr_in;
      sync2_r <= sync1_r;
    end
  end

  assign req_s = sync2_r;
`else
  assign req_s = intr_in;
`endif

  assign edge_s = req_s & ~prev_r;
  // TAKEN never sees a real instruction boundary, so all qualified actions are gated to RUN
  assign done_s = instr_done & (state_r == RUN);
  assign wr_s   = csr_we & done_s;

  // next-state logic of the entry FSM
  always_comb begin
    state_nxt = state_r;
    take_s    = 1'b0;
    case (state_r)
      RUN: begin
        if (done_s & pending_r & mie_r) begin
          state_nxt = TAKEN;
          take_s    = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      TAKEN:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // CSR next values; later assignments override earlier ones (entry > MRET > write)
  always_comb begin
    mie_nxt   = mie_r;
    mpie_nxt  = mpie_r;
    mtvec_nxt = mtvec_r;
    mepc_nxt  = mepc_r;
    if (wr_s) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_nxt  = csr_wd[3];
          mpie_nxt = csr_wd[7];
        end
        ADDR_MTVEC: mtvec_nxt = word_align(csr_wd);
        ADDR_MEPC:  mepc_nxt  = word_align(csr_wd);
        default:    mtvec_nxt = mtvec_r;
      endcase
    end else begin
      mtvec_nxt = mtvec_r;
    end
    if (mret_exec & done_s) begin
      mie_nxt  = mpie_r;
      mpie_nxt = 1'b1;
    end else begin
      mpie_nxt = mpie_nxt;
    end
    if (take_s) begin
      mepc_nxt = word_align(pc_next);
      mpie_nxt = mie_r;
      mie_nxt  = 1'b0;
    end else begin
      mepc_nxt = mepc_nxt;
    end
  end

  // state, pending flag and CSR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RUN;
      prev_r    <= 1'b0;
      pending_r <= 1'b0;
      mie_r     <= 1'b0;
      mpie_r    <= 1'b0;
      mepc_r    <= 32'h0000_0000;
      mtvec_r   <= word_align(MTVEC_RST);
    end else begin
      state_r <= state_nxt;
      prev_r  <= req_s;
      if (take_s) begin
        pending_r <= 1'b0;
      end else if (edge_s) begin
        pending_r <= 1'b1;
      end
      mie_r   <= mie_nxt;
      mpie_r  <= mpie_nxt;
      mepc_r  <= mepc_nxt;
      mtvec_r <= mtvec_nxt;
    end
  end

  assign mstatus_s = {24'h00_0000, mpie_r, 3'b000, mie_r, 3'b000};

  // zero-latency CSR read mux
  always_comb begin
    csr_rd = 32'h0000_0000;
    case (csr_addr)
      ADDR_MSTATUS: csr_rd = mstatus_s;
      ADDR_MTVEC:   csr_rd = mtvec_r;
      ADDR_MEPC:    csr_rd = mepc_r;
      default:      csr_rd = 32'h0000_0000;
    endcase
  end

  assign intr_taken = (state_r == TAKEN);
  assign mtvec      = mtvec_r;
  assign mepc       = mepc_r;
  assign mie        = mie_r;

endmodule

// File: tb/tb_otter_intr_csr.sv
// Scoreboard bench for otter_intr_csr: stimulus queues expectations, a monitor compares on the falling edge.
module tb_otter_intr_csr;

`ifdef OTTER_INTR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        intr_in = 1'b0;
  logic        instr_done = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        mret_exec = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = 12'h300;
  logic [31:0] csr_wd = 32'h0;
  logic [31:0] csr_rd, mtvec, mepc;
  logic        intr_taken, mie;

  otter_intr_csr #(.MTVEC_RST(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .intr_in(intr_in), .instr_done(instr_done),
    .pc_next(pc_next), .mret_exec(mret_exec), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wd(csr_wd), .csr_rd(csr_rd), .intr_taken(intr_taken), .mtvec(mtvec),
    .mepc(mepc), .mie(mie)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t chk_q[$];
  int   taken_q[$];
  int   tests = 0;
  int   fails = 0;
  event probe_ev;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0: return csr_rd;
      1: return mtvec;
      2: return mepc;
      3: return {31'h0, mie};
      default: return {31'h0, intr_taken};
    endcase
  endfunction

  // monitor: drains queued checks and matches every intr_taken cycle against the expected cycle
  initial begin
    int last_cyc = -1;
    forever begin
      @(negedge clk or probe_ev);
      if (intr_taken === 1'b1 && cyc != last_cyc) begin
        last_cyc = cyc;
        tests++;
        if (taken_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_taken: intr_taken high at cycle %0d, required no entry", cyc);
        end else begin
          int e;
          e = taken_q.pop_front();
          if (cyc != e) begin
            fails++;
            $display("FAIL taken_cycle: intr_taken at cycle %0d, required cycle %0d", cyc, e);
          end
        end
      end
      while (chk_q.size() > 0) begin
        chk_t c;
        c = chk_q.pop_front();
        tests++;
        if (actual(c.sel) !== c.exp) begin
          fails++;
          $display("FAIL %s: got 32'h%08h, required 32'h%08h", c.name, actual(c.sel), c.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    chk_t c;
    c.sel = sel; c.exp = exp; c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
    csr_addr = addr;
    chk(0, exp, name);
    step();
  endtask

  task automatic instr(input logic [31:0] pc, input logic mret, input logic we,
                       input logic [11:0] addr, input logic [31:0] wd);
    pc_next = pc; mret_exec = mret; csr_we = we; csr_addr = addr; csr_wd = wd;
    instr_done = 1'b1;
    step();
    instr_done = 1'b0; mret_exec = 1'b0; csr_we = 1'b0;
  endtask

  task automatic pulse();
    intr_in = 1'b1;
    step(); step();
    intr_in = 1'b0;
    repeat (LAT + 2) step();
  endtask

  task automatic expect_taken();
    taken_q.push_back(cyc + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    chk(4, 32'h0, "rst_taken");
    chk(1, 32'h100, "rst_mtvec");
    chk(2, 32'h0, "rst_mepc");
    chk(3, 32'h0, "rst_mie");
    chk(0, 32'h0, "rst_mstatus");
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // CSR writes and reads
    instr(32'h0, 1'b0, 1'b1, 12'h305, 32'h0000_0203);
    rd(12'h305, 32'h0000_0200, "wr_mtvec");
    instr(32'h0, 1'b0, 1'b1, 12'h341, 32'hFFFF_FFFF);
    rd(12'h341, 32'hFFFF_FFFC, "wr_mepc");
    instr(32'h0, 1'b0, 1'b1, 12'h300, 32'h0000_0088);
    rd(12'h300, 32'h0000_0088, "wr_mstatus");
    rd(12'h7C0, 32'h0, "rd_unknown");
    chk(3, 32'h1, "mie_out");
    csr_we = 1'b1; csr_addr = 12'h305; csr_wd = 32'h0000_0ABC;
    step();
    csr_we = 1'b0;
    rd(12'h305, 32'h0000_0200, "wr_unqualified");

    // entry, with an mtvec write landing on the entry edge
    pulse();
    expect_taken();
    instr(32'h44, 1'b0, 1'b1, 12'h305, 32'h0000_0401);
    step();
    chk(2, 32'h44, "entry_mepc");
    chk(1, 32'h400, "entry_mtvec_wr");
    rd(12'h300, 32'h80, "entry_mstatus");
    instr(32'h0, 1'b0, 1'b1, 12'h300, 32'h8);
    chk(4, 32'h0, "same_edge_mie_wr");
    instr(32'h48, 1'b0, 1'b0, 12'h0, 32'h0);
    chk(4, 32'h0, "pending_cleared");
    step();

    // masked request stays pending
    instr(32'h0, 1'b0, 1'b1, 12'h300, 32'h0);
    pulse();
    for (int i = 0; i < 5; i++) begin
      instr(32'h60, 1'b0, 1'b0, 12'h0, 32'h0);
      chk(4, 32'h0, "masked");
    end
    instr(32'h0, 1'b0, 1'b1, 12'h300, 32'h8);
    chk(4, 32'h0, "unmask_edge");
    expect_taken();
    instr(32'h80, 1'b0, 1'b0, 12'h0, 32'h0);
    step();
    chk(2, 32'h80, "unmask_mepc");
    rd(12'h300, 32'h80, "unmask_mstatus");

    // MRET
    instr(32'h0, 1'b1, 1'b0, 12'h0, 32'h0);
    rd(12'h300, 32'h88, "mret_mstatus");
    chk(3, 32'h1, "mret_mie");

    // entry coinciding with MRET
    pulse();
    expect_taken();
    instr(32'h1236, 1'b1, 1'b0, 12'h0, 32'h0);
    step();
    chk(2, 32'h1234, "mret_entry_mepc");
    rd(12'h300, 32'h80, "mret_entry_mstatus");
    chk(3, 32'h0, "mret_entry_mie");

    // request-to-entry latency with instr_done held
    instr(32'h0, 1'b0, 1'b1, 12'h300, 32'h8);
    intr_in = 1'b1; instr_done = 1'b1; pc_next = 32'h200;
    taken_q.push_back(cyc + 2 + LAT);
    repeat (LAT + 4) step();
    intr_in = 1'b0; instr_done = 1'b0;
    chk(2, 32'h200, "latency_mepc");
    step();

    // async reset in TAKEN
    instr(32'h0, 1'b0, 1'b1, 12'h300, 32'h8);
    pulse();
    expect_taken();
    instr(32'h300, 1'b0, 1'b0, 12'h0, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk(4, 32'h0, "rst_in_taken");
    chk(2, 32'h0, "rst_in_taken_mepc");
    -> probe_ev;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) step();

    tests++;
    if (taken_q.size() != 0 || chk_q.size() != 0) begin
      fails++;
      $display("FAIL leftover: %0d taken and %0d checks outstanding, required 0 and 0",
               taken_q.size(), chk_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
